// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host interface: opcodes, FSM states and payload lengths.
package tpu_pkg;

    localparam logic [7:0] OP_LOAD_W = 8'h01;
    localparam logic [7:0] OP_LOAD_A = 8'h02;
    localparam logic [7:0] OP_START  = 8'h03;
    localparam logic [7:0] OP_READ   = 8'h04;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_PAYLOAD   = 2'd1;
    localparam logic [1:0] ST_WAIT_CORE = 2'd2;
    localparam logic [1:0] ST_READOUT   = 2'd3;

    typedef enum logic [1:0] {
        IDLE      = ST_IDLE,
        PAYLOAD   = ST_PAYLOAD,
        WAIT_CORE = ST_WAIT_CORE,
        READOUT   = ST_READOUT
    } state_e;

    localparam int LEN_LOAD_W = 4;
    localparam int LEN_LOAD_A = 2;
    localparam int LEN_READ   = 4;

endpackage

// File: rtl/tpu_req_sync.sv
// Two-flop synchronizer for the asynchronous host_req strobe plus rise/fall detection.
module tpu_req_sync (
    input  logic clk,
    input  logic rst,
    input  logic host_req,
    output logic req_rise,
    output logic req_fall,
    output logic req_lvl
);

    logic sync_p0, sync_p1, sync_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            sync_p2 <= 1'b0;
        end else begin
            sync_p0 <= host_req;
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

    assign req_lvl  = sync_p1;
    assign req_rise = sync_p1 & ~sync_p2;
    assign req_fall = ~sync_p1 & sync_p2;

endmodule

// File: rtl/tpu_host_if.sv
// Byte-wide 4-phase host interface to a 2x2 int8 systolic core.
// Optional build macro TPU_HOST_IF_CKSUM_EN adds a trailing XOR checksum byte to LOAD_W/LOAD_A.
module tpu_host_if
    import tpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  host_data,
    input  logic        host_req,
    output logic        host_ack,
    output logic [7:0]  host_rdata,
    output logic        busy,
    output logic        err,
    output logic [31:0] w_data,
    output logic [15:0] a_data,
    output logic        start,
    input  logic        core_done,
    input  logic [31:0] core_result
);

    logic        req_rise, req_fall, req_lvl;
    state_e      state;
    logic [1:0]  cnt;
    logic        tgt_w;
    logic [31:0] staging;
    logic [31:0] result;
    logic        pend;
    logic        accept;
    logic        last;
    logic [31:0] assembled;
`ifdef TPU_HOST_IF_CKSUM_EN
    logic        ck_phase;
    logic [7:0]  ck_acc;
`endif

    tpu_req_sync u_req_sync (
        .clk      (clk),
        .rst      (rst),
        .host_req (host_req),
        .req_rise (req_rise),
        .req_fall (req_fall),
        .req_lvl  (req_lvl)
    );

    // A request seen while busy or still acked is remembered and served once the FSM can take it
    assign accept = (req_rise | (pend & req_lvl)) & ~host_ack & (state != WAIT_CORE);
    assign last   = tgt_w ? (cnt == 2'(LEN_LOAD_W - 1)) : (cnt == 2'(LEN_LOAD_A - 1));

    always_comb begin
        assembled = staging;
        assembled[8*cnt +: 8] = host_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            tgt_w      <= 1'b0;
            staging    <= 32'd0;
            result     <= 32'd0;
            pend       <= 1'b0;
            host_ack   <= 1'b0;
            host_rdata <= 8'h00;
            busy       <= 1'b0;
            err        <= 1'b0;
            w_data     <= 32'd0;
            a_data     <= 16'd0;
            start      <= 1'b0;
`ifdef TPU_HOST_IF_CKSUM_EN
            ck_phase   <= 1'b0;
            ck_acc     <= 8'h00;
`endif
        end else begin
            start <= 1'b0;

            if (req_fall) begin
                host_ack <= 1'b0;
                pend     <= 1'b0;
            end else if (req_rise && !accept) begin
                pend <= 1'b1;
            end

            if (accept) begin
                host_ack <= 1'b1;
                pend     <= 1'b0;
                case (state)
                    IDLE: begin
                        cnt <= 2'd0;
`ifdef TPU_HOST_IF_CKSUM_EN
                        ck_phase <= 1'b0;
                        ck_acc   <= 8'h00;
`endif
                        case (host_data)
                            OP_LOAD_W: begin
                                tgt_w <= 1'b1;
                                state <= PAYLOAD;
                            end
                            OP_LOAD_A: begin
                                tgt_w <= 1'b0;
                                state <= PAYLOAD;
                            end
                            OP_START: begin
                                start <= 1'b1;
                                busy  <= 1'b1;
                                state <= WAIT_CORE;
                            end
                            OP_READ:  state <= READOUT;
                            default:  err <= 1'b1;
                        endcase
                    end
                    PAYLOAD: begin
`ifdef TPU_HOST_IF_CKSUM_EN
                        if (ck_phase) begin
                            if (host_data == ck_acc) begin
                                if (tgt_w) w_data <= staging;
                                else       a_data <= staging[15:0];
                            end else begin
                                err <= 1'b1;
                            end
                            state <= IDLE;
                        end else begin
                            staging[8*cnt +: 8] <= host_data;
                            ck_acc <= ck_acc ^ host_data;
                            cnt    <= cnt + 2'd1;
                            if (last) ck_phase <= 1'b1;
                        end
`else
                        staging[8*cnt +: 8] <= host_data;
                        cnt <= cnt + 2'd1;
                        if (last) begin
                            if (tgt_w) w_data <= assembled;
                            else       a_data <= assembled[15:0];
                            state <= IDLE;
                        end
`endif
                    end
                    READOUT: begin
                        host_rdata <= result[8*cnt +: 8];
                        cnt <= cnt + 2'd1;
                        if (cnt == 2'(LEN_READ - 1)) state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end

            if (state == WAIT_CORE && core_done) begin
                result <= core_result;
                busy   <= 1'b0;
                state  <= IDLE;
            end
        end
    end

endmodule

// File: doc/tpu_host_if.md
TPU_HOST_IF -- requirements
Module: tpu_host_if

Interface
REQ-001 The block SHALL have these ports: clk, input, 1, sole clock, rising-edge.
REQ-002 The block SHALL have these ports: rst, input, 1, synchronous active-high reset.
REQ-003 The block SHALL have these ports: host_data, input, 8, command/payload byte from host (ui_in).
REQ-004 The block SHALL have these ports: host_req, input, 1, 4-phase request strobe from host (uio_in[0]), asynchronous to clk.
REQ-005 The block SHALL have these ports: host_ack, output, 1, 4-phase acknowledge to host (uio_out[1]).
REQ-006 The block SHALL have these ports: host_rdata, output, 8, readback byte to host (uo_out).
REQ-007 The block SHALL have these ports: busy, output, 1, high while waiting on core (uio_out[2]).
REQ-008 The block SHALL have these ports: err, output, 1, sticky protocol error (uio_out[3]).
REQ-009 The block SHALL have these ports: w_data, output, 32, 2x2 int8 weights {w11,w10,w01,w00}, to core.
REQ-010 The block SHALL have these ports: a_data, output, 16, 2 int8 activations {a1,a0}, to core.
REQ-011 The block SHALL have these ports: start, output, 1, one-cycle compute pulse to core.
REQ-012 The block SHALL have these ports: core_done, input, 1, one-cycle completion pulse from core.
REQ-013 The block SHALL have these ports: core_result, input, 32, four int8 results, valid when core_done is high.

Function
REQ-014 host_req SHALL pass a 2-flop synchronizer; a byte SHALL be accepted on the synchronized rising edge, with host_data sampled in that same cycle.
REQ-015 host_ack SHALL rise on the 3rd clk edge after host_req rises, and SHALL fall on the 3rd edge after host_req falls.
REQ-016 A new request SHALL NOT be accepted while host_ack is high.
REQ-017 FSM states SHALL be IDLE, PAYLOAD, WAIT_CORE and READOUT.
REQ-018 IDLE: each accepted byte SHALL be an opcode.
  - 0x01 LOAD_W: go to PAYLOAD, 4 bytes.
  - 0x02 LOAD_A: go to PAYLOAD, 2 bytes.
  - 0x03 START: pulse start 1 cycle, go to WAIT_CORE.
  - 0x04 READ: go to READOUT, 4 bytes.
  - Any other opcode: set err and stay in IDLE.
REQ-019 PAYLOAD SHALL store bytes LSB-first into a staging register; after the last byte it SHALL commit staging to w_data or a_data in one cycle and return to IDLE.
REQ-020 WAIT_CORE SHALL hold busy=1 and withhold host_ack for new requests; on core_done it SHALL latch core_result into the result register, drop busy and go to IDLE.
REQ-021 READOUT: on each accepted request, host_rdata SHALL present result byte k (k=0..3, LSB first) in the same cycle host_ack rises; after byte 3 the FSM SHALL return to IDLE.
REQ-022 The payload/readout byte counter SHALL be 2 bits and SHALL be cleared on every opcode acceptance.
REQ-023 core_done arriving outside WAIT_CORE SHALL be ignored and SHALL NOT set err.
REQ-024 READ with no completed compute SHALL return the result register's reset value, 0x00 bytes.
REQ-025 err SHALL be cleared only by rst.

Reset
REQ-026 rst SHALL set the following:
  - state=IDLE;
  - host_ack, start, busy and err = 0;
  - host_rdata = 0x00;
  - w_data, a_data, staging and result = 0;
  - counter and synchronizer flops = 0.
REQ-027 rst asserted mid-PAYLOAD SHALL discard staging, leave the committed w_data/a_data zeroed, and drop host_ack on the next edge.

Configuration
REQ-028 With TPU_HOST_IF_CKSUM_EN defined, LOAD_W/LOAD_A SHALL take one extra trailing byte equal to the XOR of the payload bytes.
  - Mismatch: set err and do not commit.
  - Match: commit.
REQ-029 Without TPU_HOST_IF_CKSUM_EN, no checksum byte SHALL exist and commit SHALL follow the last payload byte.

Structure
REQ-030 A shared package tpu_pkg SHALL hold:
  - opcode constants;
  - the FSM state enum;
  - payload lengths (LOAD_W=4, LOAD_A=2, READ=4).
REQ-031 The synchronizer and edge detector SHALL be sub-module tpu_req_sync (outputs: req_rise, req_fall, req_lvl).

Verification
REQ-032 Handshake: raise host_req and hold it -> host_ack high 3 cycles later; drop host_req -> host_ack low 3 cycles later.
REQ-033 LOAD_W: send 0x01,0x11,0x22,0x33,0x44 -> w_data=0x44332211; a_data unchanged; err=0.
REQ-034 Compute: send LOAD_A 0x05,0xFB, then START -> start pulses 1 cycle and busy=1. Acks are withheld until core_done with core_result=0xDEADBEEF. Then READ returns 0xEF,0xBE,0xAD,0xDE.
REQ-035 Illegal opcode 0x7F -> err=1 and the FSM stays in IDLE; a following LOAD_A still works; err stays 1 until rst.
REQ-036 Reset after 2 of 4 LOAD_W bytes -> w_data=0; the next LOAD_W loads correctly.
REQ-037 With CKSUM_EN: send 0x02,0x0F,0xF0,0xFF -> commit. Send 0x02,0x0F,0xF0,0x00 -> err=1 and a_data unchanged.
